// File: rtl/traffic_pkg.sv
// Shared types for the two-approach intersection controller: FSM state codes,
// active-low lamp patterns and the per-approach lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        GREEN_A  = 3'd1,
        AMBER_A  = 3'd2,
        ALLRED_B = 3'd3,
        GREEN_B  = 3'd4,
        AMBER_B  = 3'd5,
        FLASH    = 3'd6
    } state_t;

    // Active-low lamps: bit2=amber, bit1=red, bit0=green.
    localparam logic [2:0] LAMP_RED   = 3'b101;
    localparam logic [2:0] LAMP_GREEN = 3'b110;
    localparam logic [2:0] LAMP_AMBER = 3'b011;
    localparam logic [2:0] LAMP_DARK  = 3'b111;

    function automatic logic [2:0] lamp_a(input state_t s, input logic blink);
        case (s)
            GREEN_A: return LAMP_GREEN;
            AMBER_A: return LAMP_AMBER;
            FLASH:   return blink ? LAMP_AMBER : LAMP_DARK;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input state_t s, input logic blink);
        case (s)
            GREEN_B: return LAMP_GREEN;
            AMBER_B: return LAMP_AMBER;
            FLASH:   return blink ? LAMP_AMBER : LAMP_DARK;
            default: return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each controller phase. Load beats tick;
// the count parks at zero until the next load.
module phase_timer #(
    parameter int               CNT_W     = 4,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] r_value;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= RESET_VAL;
        end else if (load) begin
            r_value <= load_val;
        end else if (tick && (r_value != '0)) begin
            r_value <= r_value - CNT_W'(1);
        end
    end

    assign value = r_value;
    assign zero  = (r_value == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection sequencer with pedestrian green cut-short,
// emergency all-red preemption and a flashing-amber maintenance mode.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W           = 4,
    parameter int GREEN_TICKS     = 5,
    parameter int AMBER_TICKS     = 2,
    parameter int ALLRED_TICKS    = 1,
    parameter int MIN_GREEN_TICKS = 2,
    parameter int FLASH_TICKS     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       emergency,
    input  logic       flash_en,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic [2:0] phase,
    output logic       ped_pend
);

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] AMBER_LOAD  = CNT_W'(AMBER_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_TICKS - 1);
    // Counter value at or below which MIN_GREEN_TICKS have elapsed, counting the current tick.
    localparam logic [CNT_W-1:0] GREEN_CUT_AT = CNT_W'(GREEN_TICKS - MIN_GREEN_TICKS);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_blink;
    logic             w_next_blink;
    logic             r_ped_pend;
    logic [2:0]       r_light_a;
    logic [2:0]       r_light_b;
    logic [2:0]       r_phase;
    logic             w_reload;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_zero;
    logic             w_expire;
    logic             w_ped_cut;
    logic             w_enter_amber;

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (ALLRED_LOAD)
    ) u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick),
        .value    (w_cnt),
        .zero     (w_zero)
    );

    assign w_expire  = tick && w_zero;
    assign w_ped_cut = tick && r_ped_pend && (w_cnt <= GREEN_CUT_AT);

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_next_blink = r_blink;
        w_reload     = 1'b0;
        case (r_state)
            ALLRED_A: begin
                if (emergency) begin
                    w_reload = 1'b1;
                end else if (w_expire) begin
                    if (flash_en) w_next_state = FLASH;
                    else          w_next_state = GREEN_A;
                end
            end
            ALLRED_B: begin
                if (emergency) begin
                    w_next_state = ALLRED_A;
                end else if (w_expire) begin
                    if (flash_en) w_next_state = FLASH;
                    else          w_next_state = GREEN_B;
                end
            end
            GREEN_A: if (emergency || w_expire || w_ped_cut) w_next_state = AMBER_A;
            GREEN_B: if (emergency || w_expire || w_ped_cut) w_next_state = AMBER_B;
            AMBER_A: begin
                if (w_expire) begin
                    if (emergency) w_next_state = ALLRED_A;
                    else           w_next_state = ALLRED_B;
                end
            end
            AMBER_B: if (w_expire) w_next_state = ALLRED_A;
            FLASH: begin
                if (emergency || !flash_en) begin
                    w_next_state = ALLRED_A;
                end else if (w_expire) begin
                    w_reload     = 1'b1;
                    w_next_blink = ~r_blink;
                end
            end
            default: w_next_state = ALLRED_A;
        endcase
        // Flash always opens with the amber half so the mode is visible at once.
        if ((w_next_state == FLASH) && (r_state != FLASH)) w_next_blink = 1'b1;
    end

    always_comb begin
        case (w_next_state)
            GREEN_A, GREEN_B: w_load_val = GREEN_LOAD;
            AMBER_A, AMBER_B: w_load_val = AMBER_LOAD;
            FLASH:            w_load_val = FLASH_LOAD;
            default:          w_load_val = ALLRED_LOAD;
        endcase
    end

    assign w_load        = w_reload || (w_next_state != r_state);
    assign w_enter_amber = (w_next_state != r_state) &&
                           ((w_next_state == AMBER_A) || (w_next_state == AMBER_B));

    // Lamps and phase are decoded from the next state so they switch with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ALLRED_A;
            r_blink    <= 1'b0;
            r_ped_pend <= 1'b0;
            r_light_a  <= LAMP_RED;
            r_light_b  <= LAMP_RED;
            r_phase    <= 3'd0;
        end else begin
            r_state    <= w_next_state;
            r_blink    <= w_next_blink;
            r_ped_pend <= ped_req | (r_ped_pend & ~w_enter_amber);
            r_light_a  <= lamp_a(w_next_state, w_next_blink);
            r_light_b  <= lamp_b(w_next_state, w_next_blink);
            r_phase    <= w_next_state;
        end
    end

    assign light_a  = r_light_a;
    assign light_b  = r_light_b;
    assign phase    = r_phase;
    assign ped_pend = r_ped_pend;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default parameters: normal cycle,
// pedestrian cut-short, emergency preemption, flash mode and tick stretching.
module tb_traffic_light_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    // One row per clock: inputs applied before the edge, expectations after it.
    typedef struct packed {
        logic       tk;
        logic       pr;
        logic       em;
        logic       fe;
        logic [2:0] ph;
        logic       bl;
        logic       pp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       emergency = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic [2:0] phase;
    logic       ped_pend;

    int n_pass = 0;
    int n_total = 0;
    int n_viol = 0;

    always #5 clock = ~clock;

    traffic_light_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .ped_req   (ped_req),
        .emergency (emergency),
        .flash_en  (flash_en),
        .light_a   (light_a),
        .light_b   (light_b),
        .phase     (phase),
        .ped_pend  (ped_pend)
    );

    // Safety: the two green lamps (active-low bit0) must never be lit together.
    always @(negedge clock) begin
        if (!reset && light_a[0] === 1'b0 && light_b[0] === 1'b0) begin
            n_viol++;
            $display("FAIL safety_two_greens: light_a=%b light_b=%b at %0t", light_a, light_b, $time);
        end
    end

    function automatic logic [2:0] exp_a(input logic [2:0] ph, input logic bl);
        case (ph)
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd6:    return bl ? 3'b011 : 3'b111;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [2:0] exp_b(input logic [2:0] ph, input logic bl);
        case (ph)
            3'd4:    return 3'b110;
            3'd5:    return 3'b011;
            3'd6:    return bl ? 3'b011 : 3'b111;
            default: return 3'b101;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b1; ped_req = 1'b0; emergency = 1'b0; flash_en = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1;
        step();
        step();
        n_total++; if (phase !== 3'd0) $display("FAIL reset_phase: got %0d want 0", phase); else n_pass++;
        n_total++; if (light_a !== 3'b101) $display("FAIL reset_light_a: got %b want 101", light_a); else n_pass++;
        n_total++; if (light_b !== 3'b101) $display("FAIL reset_light_b: got %b want 101", light_b); else n_pass++;
        n_total++; if (ped_pend !== 1'b0) $display("FAIL reset_ped_pend: got %b want 0", ped_pend); else n_pass++;
    endtask

    task automatic test_normal_cycle();
        logic [2:0] pat [16] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                                 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0};
        reset = 1'b0; tick = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            n_total++;
            if (phase !== pat[k % 16]) $display("FAIL cycle[%0d]_phase: got %0d want %0d", k, phase, pat[k % 16]);
            else n_pass++;
            n_total++;
            if (light_a !== exp_a(pat[k % 16], 1'b0)) $display("FAIL cycle[%0d]_light_a: got %b want %b", k, light_a, exp_a(pat[k % 16], 1'b0));
            else n_pass++;
            n_total++;
            if (light_b !== exp_b(pat[k % 16], 1'b0)) $display("FAIL cycle[%0d]_light_b: got %b want %b", k, light_b, exp_b(pat[k % 16], 1'b0));
            else n_pass++;
        end
    endtask

    task automatic test_ped();
        vec_t v [13] = '{
            '{H, L, L, L, 3'd1, L, L},
            '{H, H, L, L, 3'd1, L, H},
            '{H, L, L, L, 3'd2, L, L},
            '{H, L, L, L, 3'd2, L, L},
            '{H, L, L, L, 3'd3, L, L},
            '{H, H, L, L, 3'd4, L, H},
            '{H, H, L, L, 3'd4, L, H},
            '{H, H, L, L, 3'd5, L, H},
            '{H, L, L, L, 3'd5, L, H},
            '{H, L, L, L, 3'd0, L, H},
            '{H, L, L, L, 3'd1, L, H},
            '{H, L, L, L, 3'd1, L, H},
            '{H, L, L, L, 3'd2, L, L}};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            tick = v[i].tk; ped_req = v[i].pr; emergency = v[i].em; flash_en = v[i].fe;
            step();
            n_total++; if (phase !== v[i].ph) $display("FAIL ped[%0d]_phase: got %0d want %0d", i, phase, v[i].ph); else n_pass++;
            n_total++; if (light_a !== exp_a(v[i].ph, v[i].bl)) $display("FAIL ped[%0d]_light_a: got %b want %b", i, light_a, exp_a(v[i].ph, v[i].bl)); else n_pass++;
            n_total++; if (light_b !== exp_b(v[i].ph, v[i].bl)) $display("FAIL ped[%0d]_light_b: got %b want %b", i, light_b, exp_b(v[i].ph, v[i].bl)); else n_pass++;
            n_total++; if (ped_pend !== v[i].pp) $display("FAIL ped[%0d]_ped_pend: got %b want %b", i, ped_pend, v[i].pp); else n_pass++;
        end
        ped_req = 1'b0;
    endtask

    task automatic test_emergency();
        vec_t v [25] = '{
            '{H, L, L, L, 3'd1, L, L}, '{H, L, L, L, 3'd1, L, L}, '{H, L, L, L, 3'd1, L, L},
            '{H, L, L, L, 3'd1, L, L}, '{H, L, L, L, 3'd1, L, L}, '{H, L, L, L, 3'd2, L, L},
            '{H, L, L, L, 3'd2, L, L}, '{H, L, L, L, 3'd3, L, L}, '{H, L, L, L, 3'd4, L, L},
            '{H, L, L, L, 3'd4, L, L},
            '{H, L, H, L, 3'd5, L, L}, '{H, L, H, L, 3'd5, L, L}, '{H, L, H, L, 3'd0, L, L},
            '{H, L, H, L, 3'd0, L, L}, '{H, L, H, L, 3'd0, L, L}, '{H, L, H, L, 3'd0, L, L},
            '{H, L, H, L, 3'd0, L, L}, '{H, L, H, L, 3'd0, L, L}, '{H, L, H, L, 3'd0, L, L},
            '{H, L, H, L, 3'd0, L, L},
            '{H, L, L, L, 3'd1, L, L},
            '{L, L, H, L, 3'd2, L, L}, '{L, L, H, L, 3'd2, L, L},
            '{H, L, L, L, 3'd2, L, L}, '{H, L, L, L, 3'd3, L, L}};
        do_reset();
        for (int i = 0; i < 25; i++) begin
            tick = v[i].tk; ped_req = v[i].pr; emergency = v[i].em; flash_en = v[i].fe;
            step();
            n_total++; if (phase !== v[i].ph) $display("FAIL emerg[%0d]_phase: got %0d want %0d", i, phase, v[i].ph); else n_pass++;
            n_total++; if (light_a !== exp_a(v[i].ph, v[i].bl)) $display("FAIL emerg[%0d]_light_a: got %b want %b", i, light_a, exp_a(v[i].ph, v[i].bl)); else n_pass++;
            n_total++; if (light_b !== exp_b(v[i].ph, v[i].bl)) $display("FAIL emerg[%0d]_light_b: got %b want %b", i, light_b, exp_b(v[i].ph, v[i].bl)); else n_pass++;
        end
        emergency = 1'b0; tick = 1'b1;
    endtask

    task automatic test_flash();
        vec_t v [16] = '{
            '{H, L, L, L, 3'd1, L, L}, '{H, L, L, L, 3'd1, L, L},
            '{H, L, L, H, 3'd1, L, L}, '{H, L, L, H, 3'd1, L, L}, '{H, L, L, H, 3'd1, L, L},
            '{H, L, L, H, 3'd2, L, L}, '{H, L, L, H, 3'd2, L, L}, '{H, L, L, H, 3'd3, L, L},
            '{H, L, L, H, 3'd6, H, L}, '{H, L, L, H, 3'd6, L, L},
            '{H, L, L, H, 3'd6, H, L}, '{H, L, L, H, 3'd6, L, L},
            '{H, L, H, H, 3'd0, L, L}, '{H, L, L, H, 3'd6, H, L},
            '{H, L, L, L, 3'd0, L, L}, '{H, L, L, L, 3'd1, L, L}};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick = v[i].tk; ped_req = v[i].pr; emergency = v[i].em; flash_en = v[i].fe;
            step();
            n_total++; if (phase !== v[i].ph) $display("FAIL flash[%0d]_phase: got %0d want %0d", i, phase, v[i].ph); else n_pass++;
            n_total++; if (light_a !== exp_a(v[i].ph, v[i].bl)) $display("FAIL flash[%0d]_light_a: got %b want %b", i, light_a, exp_a(v[i].ph, v[i].bl)); else n_pass++;
            n_total++; if (light_b !== exp_b(v[i].ph, v[i].bl)) $display("FAIL flash[%0d]_light_b: got %b want %b", i, light_b, exp_b(v[i].ph, v[i].bl)); else n_pass++;
        end
        emergency = 1'b0; flash_en = 1'b0;
    endtask

    task automatic test_tick_stretch();
        do_reset();
        for (int k = 1; k <= 28; k++) begin
            tick = (k % 3 == 0);
            ped_req = (k == 28);
            step();
            if (k == 2) begin
                n_total++; if (phase !== 3'd0) $display("FAIL stretch_pre_green: got %0d want 0", phase); else n_pass++;
            end
            if (k == 3 || k == 17) begin
                n_total++; if (phase !== 3'd1) $display("FAIL stretch_green_k%0d: got %0d want 1", k, phase); else n_pass++;
            end
            if (k == 18) begin
                n_total++; if (phase !== 3'd2) $display("FAIL stretch_amber_entry: got %0d want 2", phase); else n_pass++;
            end
            if (k == 24) begin
                n_total++; if (phase !== 3'd3) $display("FAIL stretch_allred_b: got %0d want 3", phase); else n_pass++;
            end
            if (k == 28) begin
                n_total++; if (phase !== 3'd4) $display("FAIL stretch_green_b: got %0d want 4", phase); else n_pass++;
                n_total++; if (ped_pend !== 1'b1) $display("FAIL stretch_ped_latch: got %b want 1", ped_pend); else n_pass++;
            end
        end
        ped_req = 1'b0; tick = 1'b0; reset = 1'b1;
        step();
        n_total++; if (phase !== 3'd0) $display("FAIL midreset_phase: got %0d want 0", phase); else n_pass++;
        n_total++; if (light_a !== 3'b101) $display("FAIL midreset_light_a: got %b want 101", light_a); else n_pass++;
        n_total++; if (light_b !== 3'b101) $display("FAIL midreset_light_b: got %b want 101", light_b); else n_pass++;
        n_total++; if (ped_pend !== 1'b0) $display("FAIL midreset_ped_pend: got %b want 0", ped_pend); else n_pass++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped();
        test_emergency();
        test_flash();
        test_tick_stretch();
        n_total++;
        if (n_viol !== 0) $display("FAIL safety_summary: got %0d violations want 0", n_viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
